// File: rtl/fp16_dot_accum_pkg.sv
// Shared FP16 format constants, field struct and helpers for the vertex-transform adders.
package fp16_pkg;
  localparam int EXP_W     = 5;
  localparam int MANT_W    = 10;
  localparam int FP16_BIAS = 15;
  localparam logic [15:0] FP16_MAX_POS = 16'h7BFF;
  localparam logic [15:0] FP16_MAX_NEG = 16'hFBFF;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp16_t;

  typedef enum logic {ST_IDLE = 1'b0, ST_ACC = 1'b1} acc_state_e;

  // Leading-zero count of an 11-bit significand (11 when all zero).
  function automatic logic [EXP_W-1:0] lzc11(input logic [MANT_W:0] v);
    lzc11 = EXP_W'(MANT_W + 1);
    for (int i = 0; i <= MANT_W; i++)
      if (v[i]) lzc11 = EXP_W'(MANT_W - i);
  endfunction
endpackage

// File: rtl/fp16_dot_accum_fp16add.sv
// Combinational FP16 adder: flush-to-zero, truncating, saturating at the largest finite magnitude.
module fp16add
  import fp16_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y,
  output logic        ovf
);
  fp16_t             fa, fb, big, sml;
  logic [EXP_W-1:0]  d, lz;
  logic [MANT_W:0]   sig_b, sig_al, diff;
  logic [MANT_W+1:0] total;
  logic [MANT_W-1:0] norm;

  always_comb begin
    fa     = fp16_t'(a);
    fb     = fp16_t'(b);
    big    = ({fa.exp, fa.mant} >= {fb.exp, fb.mant}) ? fa : fb;
    sml    = ({fa.exp, fa.mant} >= {fb.exp, fb.mant}) ? fb : fa;
    d      = big.exp - sml.exp;
    sig_b  = {1'b1, big.mant};
    sig_al = {1'b1, sml.mant} >> d;
    total  = {1'b0, sig_b} + {1'b0, sig_al};
    diff   = sig_b - sig_al;
    lz     = lzc11(diff);
    norm   = MANT_W'(diff << lz);
    y      = 16'h0000;
    ovf    = 1'b0;
    if (big.exp == '0) begin
      y = 16'h0000;
    end else if (sml.exp == '0) begin
      y = big;
    end else if (big.sign == sml.sign) begin
      if (total[MANT_W+1]) begin
        // A carry out of exponent 30 or 31 cannot be represented below 0x7BFF.
        if (big.exp >= EXP_W'(30)) begin
          y   = big.sign ? FP16_MAX_NEG : FP16_MAX_POS;
          ovf = 1'b1;
        end else begin
          y = {big.sign, EXP_W'(big.exp + EXP_W'(1)), total[MANT_W:1]};
        end
      end else begin
        y = {big.sign, big.exp, total[MANT_W-1:0]};
      end
    end else begin
      if (diff == '0 || big.exp <= lz) y = 16'h0000;
      else                             y = {big.sign, EXP_W'(big.exp - lz), norm};
    end
  end
endmodule

// File: rtl/fp16_dot_accum.sv
// Streaming FP16 group accumulator: sums up to MAX_TERMS products and pulses the result.
module fp16_dot_accum
  import fp16_pkg::*;
#(
  parameter int MAX_TERMS = 4
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] prod,
  input  logic        in_valid,
  input  logic        in_last,
  output logic [15:0] sum,
  output logic        out_valid,
  output logic        out_ovf
);
  acc_state_e  state;
  logic [3:0]  cnt;
  logic [15:0] acc, add_a, acc_next;
  logic        ovf, add_ovf, close;

  // Opening beat adds to +0 so a denormal first term is flushed like any other.
  assign add_a = (state == ST_ACC) ? acc : 16'h0000;
  assign close = in_last || (({1'b0, cnt} + 5'd1) == 5'(MAX_TERMS));

  fp16add u_add (.a(add_a), .b(prod), .y(acc_next), .ovf(add_ovf));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      sum       <= '0;
      out_valid <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        if (close) begin
          sum       <= acc_next;
          out_ovf   <= ovf | add_ovf;
          out_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
          ovf       <= 1'b0;
          state     <= ST_IDLE;
        end else begin
          acc   <= acc_next;
          cnt   <= cnt + 4'd1;
          ovf   <= ovf | add_ovf;
          state <= ST_ACC;
        end
      end
    end
  end
endmodule

// File: tb/tb_fp16_dot_accum.sv
// Directed scoreboard bench for fp16_dot_accum with hand-derived FP16 results.
module tb_fp16_dot_accum;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] prod = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [15:0] sum;
  logic        out_valid, out_ovf;

  int errors = 0;
  int checks = 0;
  logic [16:0] sb[$];

  fp16_dot_accum #(.MAX_TERMS(4)) dut (
    .clk(clk), .rst(rst), .prod(prod), .in_valid(in_valid), .in_last(in_last),
    .sum(sum), .out_valid(out_valid), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive a beat, push the expected result if it closes a group,
  // then pop/compare any pulse produced by that edge.
  task automatic beat(input logic v, input logic [15:0] p, input logic l,
                      input logic cl, input logic [15:0] es, input logic eo);
    logic [16:0] e;
    @(negedge clk);
    in_valid = v; prod = p; in_last = l;
    if (cl) sb.push_back({eo, es});
    @(posedge clk);
    #1;
    if (out_valid) begin
      if (sb.size() == 0) chk("unexpected_pulse", out_valid, 0);
      else begin
        e = sb.pop_front();
        chk("sum", sum, e[15:0]);
        chk("ovf", out_ovf, e[16]);
      end
    end
    chk("pending", sb.size(), 0);
  endtask

  task automatic idle();
    beat(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
  endtask

  initial begin
    #1 rst = 1'b0;
    #2;
    chk("rst_sum", sum, 16'h0000);
    chk("rst_valid", out_valid, 0);
    chk("rst_ovf", out_ovf, 0);
    @(negedge clk) rst = 1'b1;

    // closed by MAX_TERMS: 1+2+3+0.5
    beat(1, 16'h3C00, 0, 0, 0, 0);
    beat(1, 16'h4000, 0, 0, 0, 0);
    beat(1, 16'h4200, 0, 0, 0, 0);
    beat(1, 16'h3800, 0, 1, 16'h4680, 0);
    idle();

    // cancellation then back-to-back single-beat group
    beat(1, 16'h4000, 0, 0, 0, 0);
    beat(1, 16'hC000, 1, 1, 16'h0000, 0);
    beat(1, 16'h3E00, 1, 1, 16'h3E00, 0);
    idle();

    // small addends: exact, truncated, denormal flushed
    beat(1, 16'h3C00, 0, 0, 0, 0);
    beat(1, 16'h1400, 1, 1, 16'h3C01, 0);
    beat(1, 16'h3C00, 0, 0, 0, 0);
    beat(1, 16'h1000, 1, 1, 16'h3C00, 0);
    beat(1, 16'h3C00, 0, 0, 0, 0);
    beat(1, 16'h0123, 1, 1, 16'h3C00, 0);

    // saturation, then ovf cleared for the next group
    beat(1, 16'h7BFF, 0, 0, 0, 0);
    beat(1, 16'h7BFF, 1, 1, 16'h7BFF, 1);
    beat(1, 16'h3C00, 1, 1, 16'h3C00, 0);

    // ovf is sticky through later non-saturating adds
    beat(1, 16'h7BFF, 0, 0, 0, 0);
    beat(1, 16'h7BFF, 0, 0, 0, 0);
    beat(1, 16'hBC00, 1, 1, 16'h7BFF, 1);

    // gap with in_last=1 but in_valid=0 is ignored
    beat(1, 16'h3C00, 0, 0, 0, 0);
    beat(0, 16'h5555, 1, 0, 0, 0);
    beat(1, 16'h3C00, 1, 1, 16'h4000, 0);

    // renormalising subtract, negative sum, underflow flush
    beat(1, 16'h4200, 0, 0, 0, 0);
    beat(1, 16'hBC00, 1, 1, 16'h4000, 0);
    beat(1, 16'hC000, 0, 0, 0, 0);
    beat(1, 16'hBC00, 1, 1, 16'hC200, 0);
    beat(1, 16'h0401, 0, 0, 0, 0);
    beat(1, 16'h8400, 1, 1, 16'h0000, 0);

    // in_last coinciding with the MAX_TERMS close yields one pulse
    beat(1, 16'h3C00, 0, 0, 0, 0);
    beat(1, 16'h3C00, 0, 0, 0, 0);
    beat(1, 16'h3C00, 0, 0, 0, 0);
    beat(1, 16'h3C00, 1, 1, 16'h4400, 0);
    idle();
    idle();
    chk("hold", sum, 16'h4400);

    // asynchronous reset mid-group discards the partial sum
    beat(1, 16'h4000, 0, 0, 0, 0);
    beat(1, 16'h4000, 0, 0, 0, 0);
    @(negedge clk) in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_sum", sum, 16'h0000);
    chk("arst_valid", out_valid, 0);
    chk("arst_ovf", out_ovf, 0);
    @(negedge clk) rst = 1'b1;
    beat(1, 16'h3C00, 1, 1, 16'h3C00, 0);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
